// File: rtl/fifo_uart_tx_pkg.sv
// Shared types and constants for the FIFO-fed UART transmitter.
package fifo_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_LOAD   = 3'd2,
        ST_START  = 3'd3,
        ST_DATA   = 3'd4,
        ST_PARITY = 3'd5,
        ST_STOP   = 3'd6
    } state_t;

    // Serial bits in a frame for the default configuration: start, 8 data, 1 stop.
    localparam int FRAME_BITS  = 10;
    localparam bit PARITY_EVEN = 1'b1;

endpackage

// File: rtl/fifo_uart_tx_if.sv
// Read-side handshake between the transmitter and the synchronous FIFO.
interface fifo_uart_tx_if #(
    parameter int WIDTH = 8
);
    logic             fifo_empty;
    logic             fifo_rd_en;
    logic [WIDTH-1:0] fifo_rd_data;

    modport master (input fifo_empty, input fifo_rd_data, output fifo_rd_en);
    modport slave  (output fifo_empty, output fifo_rd_data, input fifo_rd_en);
endinterface

// File: rtl/fifo_uart_tx_baud_tick_gen.sv
// Bit-period counter; bit_end marks the last clk cycle of each serial bit.
module baud_tick_gen #(
    parameter int CLKS_PER_BIT = 16,
    localparam int CW = $clog2(CLKS_PER_BIT)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          enable,
    output logic          bit_end,
    output logic [CW-1:0] count
);

    assign bit_end = enable && (count == CW'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= bit_end ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains a synchronous FIFO one word at a time and shifts each word out as a
// UART frame (start, LSB-first data, optional even parity, 1 or 2 stops).
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter bit PARITY_EN    = 1'b0,
    parameter int STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tx_en,
    fifo_uart_tx_if.master        fifo,
    output logic                  tx,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(WIDTH + 2);

    state_t           state, state_nx;
    logic [WIDTH-1:0] shift_reg, shift_nx;
    logic             parity;
    logic [BW-1:0]    bit_cnt;
    logic [CW-1:0]    baud_cnt;
    logic             bit_end, baud_run;
    logic             last_data, last_stop;
    logic             tx_d, rd_en_d, busy_d, done_d;

    assign baud_run  = state inside {ST_START, ST_DATA, ST_PARITY, ST_STOP};
    assign last_data = bit_cnt == BW'(WIDTH - 1);
    assign last_stop = bit_cnt == BW'(STOP_BITS - 1);

    baud_tick_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk     (clk),
        .rst     (rst),
        .clear   (!baud_run),
        .enable  (baud_run),
        .bit_end (bit_end),
        .count   (baud_cnt)
    );

    // State register; every output is a flop fed from the next-state decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_IDLE;
            tx              <= 1'b1;
            fifo.fifo_rd_en <= 1'b0;
            busy            <= 1'b0;
            frame_done      <= 1'b0;
        end else begin
            state           <= state_nx;
            tx              <= tx_d;
            fifo.fifo_rd_en <= rd_en_d;
            busy            <= busy_d;
            frame_done      <= done_d;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:   if (tx_en && !fifo.fifo_empty) state_nx = ST_FETCH;
            ST_FETCH:  state_nx = ST_LOAD;
            ST_LOAD:   state_nx = ST_START;
            ST_START:  if (bit_end) state_nx = ST_DATA;
            ST_DATA:   if (bit_end && last_data) state_nx = PARITY_EN ? ST_PARITY : ST_STOP;
            ST_PARITY: if (bit_end) state_nx = ST_STOP;
            ST_STOP:   if (bit_end && last_stop) state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        shift_nx = shift_reg;
        if (state == ST_LOAD) begin
            shift_nx = fifo.fifo_rd_data;
        end else if (state == ST_DATA && bit_end) begin
            shift_nx = shift_reg >> 1;
        end
    end

    // Line level is decoded one cycle early so tx changes exactly on bit boundaries.
    always_comb begin
        tx_d    = 1'b1;
        rd_en_d = state_nx == ST_FETCH;
        busy_d  = state_nx != ST_IDLE;
        done_d  = (state == ST_STOP) && last_stop && (baud_cnt == CW'(CLKS_PER_BIT - 2));
        case (state_nx)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_nx[0];
            ST_PARITY: tx_d = parity;
            default:   tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg <= '0;
            parity    <= 1'b0;
            bit_cnt   <= '0;
        end else begin
            shift_reg <= shift_nx;
            if (state == ST_LOAD) begin
                parity <= ^fifo.fifo_rd_data ^ ~PARITY_EVEN;
            end
            if (!baud_run) begin
                bit_cnt <= '0;
            end else if (bit_end) begin
                if ((state == ST_DATA && !last_data) || (state == ST_STOP && !last_stop)) begin
                    bit_cnt <= bit_cnt + 1'b1;
                end else begin
                    bit_cnt <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: two instances (plain 8N1 and 8E2) fed by queue-like FIFO models.
module tb_fifo_uart_tx;
    import fifo_uart_pkg::*;

    localparam int W = 8;
    localparam int C = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tx_en = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    fifo_uart_tx_if #(.WIDTH(W)) f0 ();
    fifo_uart_tx_if #(.WIDTH(W)) f1 ();
    logic tx0, busy0, fd0, tx1, busy1, fd1;

    fifo_uart_tx #(.WIDTH(W), .CLKS_PER_BIT(C), .PARITY_EN(1'b0), .STOP_BITS(1)) u0 (
        .clk(clk), .rst(rst), .tx_en(tx_en), .fifo(f0.master),
        .tx(tx0), .busy(busy0), .frame_done(fd0));
    fifo_uart_tx #(.WIDTH(W), .CLKS_PER_BIT(C), .PARITY_EN(1'b1), .STOP_BITS(2)) u1 (
        .clk(clk), .rst(rst), .tx_en(tx_en), .fifo(f1.master),
        .tx(tx1), .busy(busy1), .frame_done(fd1));

    // FIFO models: registered read data, sticky read_error on an empty read.
    logic [7:0] mem0 [256];
    logic [7:0] mem1 [256];
    int wp0 = 0, rp0 = 0, wp1 = 0, rp1 = 0;
    logic err0 = 1'b0, err1 = 1'b0;
    assign f0.fifo_empty = (rp0 == wp0);
    assign f1.fifo_empty = (rp1 == wp1);

    always @(posedge clk) begin
        if (f0.fifo_rd_en) begin
            if (rp0 == wp0) err0 <= 1'b1;
            else begin
                f0.fifo_rd_data <= mem0[rp0[7:0]];
                rp0 <= rp0 + 1;
            end
        end
    end

    always @(posedge clk) begin
        if (f1.fifo_rd_en) begin
            if (rp1 == wp1) err1 <= 1'b1;
            else begin
                f1.fifo_rd_data <= mem1[rp1[7:0]];
                rp1 <= rp1 + 1;
            end
        end
    end

    task automatic push(input int sel, input logic [7:0] b);
        if (sel == 0) begin mem0[wp0[7:0]] = b; wp0++; end
        else begin mem1[wp1[7:0]] = b; wp1++; end
    endtask

    function automatic logic tx_of(input int sel);   return sel != 0 ? tx1 : tx0; endfunction
    function automatic logic busy_of(input int sel); return sel != 0 ? busy1 : busy0; endfunction
    function automatic logic fd_of(input int sel);   return sel != 0 ? fd1 : fd0; endfunction
    function automatic logic rd_of(input int sel);   return sel != 0 ? f1.fifo_rd_en : f0.fifo_rd_en; endfunction
    function automatic int frame_len(input int sel); return (sel != 0 ? 12 : 10) * C; endfunction

    // Reference waveform: one entry per clk cycle from the start bit onward.
    function automatic logic [63:0] exp_tx(input int sel, input logic [7:0] d);
        logic [63:0] v = '0;
        for (int k = 0; k < frame_len(sel); k++) begin
            int b = k / C;
            if (b == 0) v[k] = 1'b0;
            else if (b <= W) v[k] = d[b-1];
            else if (sel != 0 && b == W + 1) v[k] = ^d;
            else v[k] = 1'b1;
        end
        return v;
    endfunction

    // Waits (bounded) for the start bit, then records one frame cycle by cycle.
    task automatic capture_frame(input int sel, output logic [63:0] tv, output logic [63:0] fv,
                                 output logic [63:0] bv, output int waits, output int rds);
        tv = '0; fv = '0; bv = '0; waits = 0; rds = 0;
        do begin
            @(negedge clk);
            waits++;
            if (rd_of(sel)) rds++;
        end while (tx_of(sel) !== 1'b0 && waits < 200);
        if (tx_of(sel) !== 1'b0) begin
            waits = -1;
            return;
        end
        for (int k = 0; k < frame_len(sel); k++) begin
            if (k > 0) @(negedge clk);
            tv[k] = tx_of(sel);
            fv[k] = fd_of(sel);
            bv[k] = busy_of(sel);
            if (rd_of(sel)) rds++;
        end
    endtask

    task automatic idle_watch(input int sel, input int n, output int rds, output int bad);
        rds = 0; bad = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (rd_of(sel)) rds++;
            if (tx_of(sel) !== 1'b1 || busy_of(sel) !== 1'b0) bad++;
        end
    endtask

    task automatic test_reset();
        int rds0, bad0, rds1, bad1;
        rst = 1'b1; tx_en = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({tx0, busy0, fd0, f0.fifo_rd_en, tx1, busy1, fd1, f1.fifo_rd_en} !== 8'b1000_1000) begin
            errors++;
            $display("FAIL reset_state got %b want 10001000",
                     {tx0, busy0, fd0, f0.fifo_rd_en, tx1, busy1, fd1, f1.fifo_rd_en});
        end
        fork
            idle_watch(0, 100, rds0, bad0);
            idle_watch(1, 100, rds1, bad1);
        join
        checks++;
        if (rds0 + rds1 !== 0 || bad0 + bad1 !== 0) begin
            errors++;
            $display("FAIL reset_idle rd_pulses %0d line_faults %0d want 0 0", rds0 + rds1, bad0 + bad1);
        end
    endtask

    task automatic test_single();
        logic [63:0] tv, fv, bv;
        int wt, rd, rds, bad;
        push(0, 8'hA5);
        capture_frame(0, tv, fv, bv, wt, rd);
        checks++;
        if (tv !== exp_tx(0, 8'hA5)) begin
            errors++; $display("FAIL single_tx got %h want %h", tv, exp_tx(0, 8'hA5));
        end
        checks++;
        if (fv !== (64'd1 << 39) || bv !== ((64'd1 << 40) - 64'd1)) begin
            errors++; $display("FAIL single_done_busy done %h busy %h", fv, bv);
        end
        checks++;
        if (wt !== 3 || rd !== 1) begin
            errors++; $display("FAIL single_latency wait %0d rd %0d want 3 1", wt, rd);
        end
        idle_watch(0, 20, rds, bad);
        checks++;
        if (rds !== 0 || bad !== 0) begin
            errors++; $display("FAIL single_after rd %0d faults %0d want 0 0", rds, bad);
        end
    endtask

    task automatic test_parity();
        logic [63:0] tv, fv, bv;
        int wt, rd, rds, bad;
        push(1, 8'h07);
        capture_frame(1, tv, fv, bv, wt, rd);
        checks++;
        if (tv !== exp_tx(1, 8'h07)) begin
            errors++; $display("FAIL parity_tx got %h want %h", tv, exp_tx(1, 8'h07));
        end
        checks++;
        if (tv[38] !== 1'b1) begin
            errors++; $display("FAIL parity_bit got %b want 1", tv[38]);
        end
        checks++;
        if (fv !== (64'd1 << 47) || bv !== ((64'd1 << 48) - 64'd1)) begin
            errors++; $display("FAIL parity_done_busy done %h busy %h", fv, bv);
        end
        idle_watch(1, 20, rds, bad);
        checks++;
        if (rds !== 0 || bad !== 0) begin
            errors++; $display("FAIL parity_after rd %0d faults %0d want 0 0", rds, bad);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [3];
        logic [63:0] tv, fv, bv;
        int wt, rd, rds, bad;
        bytes[0] = 8'h55; bytes[1] = 8'hAA; bytes[2] = 8'h0F;
        for (int i = 0; i < 3; i++) push(0, bytes[i]);
        for (int i = 0; i < 3; i++) begin
            capture_frame(0, tv, fv, bv, wt, rd);
            checks++;
            if (tv !== exp_tx(0, bytes[i]) || wt !== (i == 0 ? 3 : 4) || rd !== 1) begin
                errors++;
                $display("FAIL b2b_frame%0d tx %h want %h wait %0d rd %0d", i, tv, exp_tx(0, bytes[i]), wt, rd);
            end
        end
        idle_watch(0, 30, rds, bad);
        checks++;
        if (rds !== 0 || bad !== 0 || err0 !== 1'b0) begin
            errors++; $display("FAIL b2b_drain rd %0d faults %0d read_error %b want 0 0 0", rds, bad, err0);
        end
    endtask

    task automatic test_random_stream(input int sel, input int n);
        logic [7:0] b [8];
        logic [63:0] tv, fv, bv;
        int wt, rd;
        for (int i = 0; i < n; i++) begin
            b[i] = 8'($urandom);
            push(sel, b[i]);
        end
        for (int i = 0; i < n; i++) begin
            capture_frame(sel, tv, fv, bv, wt, rd);
            checks++;
            if (tv !== exp_tx(sel, b[i]) || fv !== (64'd1 << (frame_len(sel) - 1))) begin
                errors++;
                $display("FAIL rand%0d_frame%0d byte %h tx %h want %h done %h", sel, i, b[i], tv, exp_tx(sel, b[i]), fv);
            end
        end
    endtask

    task automatic test_tx_en_pause();
        logic [7:0] b1, b2;
        logic [63:0] tv, fv, bv;
        int wt, rd, rds, bad;
        b1 = 8'($urandom); b2 = 8'($urandom);
        push(0, b1); push(0, b2);
        fork
            capture_frame(0, tv, fv, bv, wt, rd);
            begin repeat (10) @(negedge clk); tx_en = 1'b0; end
        join
        checks++;
        if (tv !== exp_tx(0, b1) || fv !== (64'd1 << 39)) begin
            errors++; $display("FAIL pause_frame1 tx %h want %h done %h", tv, exp_tx(0, b1), fv);
        end
        idle_watch(0, 40, rds, bad);
        checks++;
        if (rds !== 0 || bad !== 0) begin
            errors++; $display("FAIL pause_hold rd %0d faults %0d want 0 0", rds, bad);
        end
        tx_en = 1'b1;
        capture_frame(0, tv, fv, bv, wt, rd);
        checks++;
        if (tv !== exp_tx(0, b2) || wt !== 3 || rd !== 1) begin
            errors++; $display("FAIL pause_frame2 tx %h want %h wait %0d rd %0d", tv, exp_tx(0, b2), wt, rd);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] b1, b2;
        logic [63:0] tv, fv, bv;
        int wt, rd, n;
        b1 = 8'($urandom); b2 = 8'($urandom);
        push(0, b1); push(0, b2);
        n = 0;
        do begin @(negedge clk); n++; end while (tx0 !== 1'b0 && n < 50);
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({tx0, busy0, fd0, f0.fifo_rd_en} !== 4'b1000 || n >= 50) begin
            errors++; $display("FAIL midreset_state got %b want 1000 (start wait %0d)", {tx0, busy0, fd0, f0.fifo_rd_en}, n);
        end
        rst = 1'b0;
        capture_frame(0, tv, fv, bv, wt, rd);
        checks++;
        if (tv !== exp_tx(0, b2) || wt !== 3) begin
            errors++; $display("FAIL midreset_next tx %h want %h wait %0d", tv, exp_tx(0, b2), wt);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_parity();
        test_back_to_back();
        test_random_stream(0, 5);
        test_random_stream(1, 4);
        test_tx_en_pause();
        test_reset_mid();
        repeat (5) @(negedge clk);
        checks++;
        if (err0 !== 1'b0 || err1 !== 1'b0 || rp0 != wp0 || rp1 != wp1) begin
            errors++; $display("FAIL fifo_final read_error %b%b left %0d %0d want 00 0 0", err0, err1, wp0 - rp0, wp1 - rp1);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Serial transmit stage that drains the synchronous FIFO from its read side and emits each WIDTH-bit word as an asynchronous UART frame: start bit, LSB-first data, optional even parity, 1 or 2 stop bits. It watches the FIFO `empty` flag, issues single-cycle `read_en` pulses, and captures the FIFO's registered `read_data`. By construction it never reads an empty FIFO, so the FIFO's read_error never fires.

## Interface
- WIDTH, 8, data bits per frame; must equal the FIFO WIDTH.
- CLKS_PER_BIT, 16, clk cycles per serial bit; legal range ≥ 2.
- PARITY_EN, 0, 1 inserts an even-parity bit after the data bits.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- tx_en  in  1  allow new frames to start; sampled in IDLE only.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd_en  out  1  registered one-cycle read request to the FIFO.
- fifo_rd_data  in  WIDTH  FIFO read_data; valid the cycle after fifo_rd_en is sampled.
- tx  out  1  serial line; idles high.
- busy  out  1  high whenever state ≠ IDLE.
- frame_done  out  1  one-cycle pulse in the last cycle of the final stop bit.

## Operation
- States: IDLE, FETCH, LOAD, START, DATA, PARITY, STOP.
- IDLE → FETCH when tx_en=1 and fifo_empty=0. In FETCH, fifo_rd_en=1; it is low in every other state.
- FETCH → LOAD unconditionally. In LOAD, shift_reg ← fifo_rd_data and parity ← ^fifo_rd_data.
- LOAD → START. Each of START, DATA (per bit), PARITY and STOP (per bit) holds for exactly CLKS_PER_BIT cycles, counted by the baud counter.
- Line levels: tx=0 in START; tx=shift_reg[0] in DATA, shifting right at each bit boundary; tx=parity in PARITY; tx=1 in STOP.
- The bit counter counts WIDTH data bits, then STOP_BITS stop bits.
- DATA → PARITY when PARITY_EN=1, otherwise DATA → STOP.
- STOP → IDLE after the last stop bit. frame_done is asserted in that final cycle.
- Only one read is outstanding at a time. The FIFO empty flag has settled before the next IDLE evaluation, so no underflow is possible.
- tx_en deasserted mid-frame: the current frame completes, then the block stays in IDLE.
- fifo_empty rising mid-frame: ignored.
- rst mid-operation: next cycle state=IDLE, tx=1, fifo_rd_en=0, busy=0, frame_done=0, counters=0. A byte already popped from the FIFO is discarded.
- Widths: baud counter $clog2(CLKS_PER_BIT); bit counter $clog2(WIDTH+2). Both wrap to 0 at each bit or state boundary.

## Timing
- Reset values: tx=1, fifo_rd_en=0, busy=0, frame_done=0.
- Start-up latency: if fifo_empty=0 is sampled in IDLE at edge E0, then:
  - fifo_rd_en is high from E0 to E1;
  - data is captured at E2;
  - tx falls at E2.
- Frame length from tx falling to the frame_done cycle inclusive: (1+WIDTH+PARITY_EN+STOP_BITS)×CLKS_PER_BIT cycles.
- Inter-frame gap: minimum 3 extra high cycles (IDLE, FETCH, LOAD) between the end of the last stop bit and the next start bit.
- All outputs are registered; no combinational path from any input to any output.

## Structure
- Package fifo_uart_pkg:
  - state enum (3 bits);
  - the constants FRAME_BITS and PARITY_EVEN.
- Sub-module baud_tick_gen:
  - parameterised by CLKS_PER_BIT;
  - inputs clear and enable;
  - output bit_end pulse in the last cycle of each bit period.
- The FSM and shift register stay in fifo_uart_tx.

## Test plan
- Reset then idle: rst for 2 cycles, fifo_empty=1 → tx=1, busy=0, fifo_rd_en never asserted for 100 cycles.
- Single byte, CLKS_PER_BIT=4, PARITY_EN=0, STOP_BITS=1, byte 0xA5:
  - exactly one fifo_rd_en pulse;
  - tx sequence per 4 cycles: 0, 1,0,1,0,0,1,0,1, 1;
  - frame_done pulses 40 cycles after tx falls (inclusive count);
  - busy stays high throughout the frame.
- Parity plus 2 stop bits, byte 0x07: parity bit=1; 12 bit periods = 48 cycles; then tx held high.
- Back-to-back: FIFO preloaded with 0x55, 0xAA, 0x0F → three frames in order, each separated by a 3-cycle gap; then fifo_empty=1 → no 4th read pulse and FIFO read_error stays 0.
- tx_en cleared during the DATA bits of frame 1 → frame 1 completes; no further fifo_rd_en while tx_en=0; frame 2 starts 3 cycles after tx_en returns high.
- rst asserted in the middle of DATA → next cycle tx=1, busy=0; after release with a non-empty FIFO, the next frame carries the following FIFO entry.
